// File: rtl/embed_mem_arb_pkg.sv
// Shared widths, latency and command types for the two-master on-chip RAM arbiter.
package embed_mem_arb_pkg;

    localparam int unsigned ADDR_W         = 12;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BE_W           = DATA_W / 8;
    localparam int unsigned MEM_RD_LATENCY = 1;

    typedef logic mst_idx_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] writedata;
    } avl_cmd_t;

endpackage

// File: rtl/embed_rr_arb2.sv
// Two-request round-robin grant with the last_grant register.
// On contention the master other than the previous winner is granted.
module embed_rr_arb2
    import embed_mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic [1:0] req,
    output logic     gnt_valid,
    output mst_idx_t gnt_idx
);

    mst_idx_t last_grant_q;

    always_comb begin
        gnt_valid = (|req) & ~reset;
        case (req)
            2'b11:   gnt_idx = ~last_grant_q;
            2'b10:   gnt_idx = 1'b1;
            default: gnt_idx = 1'b0;
        endcase
    end

    // Reset value 1 lets master 0 win the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (gnt_valid) begin
            last_grant_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/embed_onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
// Define ARB_STATS_EN to add grant/contention counters and the stats_clr input.
module embed_onchip_mem_arbiter
#(
    parameter int unsigned ADDR_W = embed_mem_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W = embed_mem_arb_pkg::DATA_W,
    parameter int unsigned BE_W   = embed_mem_arb_pkg::BE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
`ifdef ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       m0_grant_cnt,
    output logic [15:0]       m1_grant_cnt,
    output logic [15:0]       contention_cnt,
`endif
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);
    import embed_mem_arb_pkg::mst_idx_t;
    import embed_mem_arb_pkg::avl_cmd_t;

    avl_cmd_t cmd0, cmd1, sel;
    logic [1:0] req;
    logic       gnt_valid;
    mst_idx_t   gnt_idx;
    logic       sel_rd;
    logic       rd_pend_q;
    mst_idx_t   rd_owner_q;

    always_comb begin
        cmd0 = '{address: m0_address, byteenable: m0_byteenable, read: m0_read,
                 write: m0_write, writedata: m0_writedata};
        cmd1 = '{address: m1_address, byteenable: m1_byteenable, read: m1_read,
                 write: m1_write, writedata: m1_writedata};
        req  = {m1_read | m1_write, m0_read | m0_write};
    end

    embed_rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Idle cycles leave master 0's command on the RAM address bus.
    always_comb begin
        sel            = (gnt_valid && gnt_idx) ? cmd1 : cmd0;
        sel_rd         = gnt_valid & sel.read & ~sel.write;
        mem_address    = sel.address;
        mem_byteenable = sel.byteenable;
        mem_writedata  = sel.writedata;
        mem_chipselect = gnt_valid;
        mem_write      = gnt_valid & sel.write;
        mem_clken      = ~reset;
        m0_waitrequest = reset | (req[0] & ~(gnt_valid & (gnt_idx == 1'b0)));
        m1_waitrequest = reset | (req[1] & ~(gnt_valid & (gnt_idx == 1'b1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q <= sel_rd;
            if (sel_rd) begin
                rd_owner_q <= gnt_idx;
            end
        end
    end

    // Masking with reset drops a response whose read was granted just before reset.
    always_comb begin
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
        m0_readdatavalid = rd_pend_q & (rd_owner_q == 1'b0) & ~reset;
        m1_readdatavalid = rd_pend_q & (rd_owner_q == 1'b1) & ~reset;
    end

`ifdef ARB_STATS_EN
    logic [15:0] m0_cnt_q, m1_cnt_q, cont_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            m0_cnt_q   <= '0;
            m1_cnt_q   <= '0;
            cont_cnt_q <= '0;
        end else begin
            if (gnt_valid && !gnt_idx && m0_cnt_q != 16'hFFFF) begin
                m0_cnt_q <= m0_cnt_q + 16'd1;
            end
            if (gnt_valid && gnt_idx && m1_cnt_q != 16'hFFFF) begin
                m1_cnt_q <= m1_cnt_q + 16'd1;
            end
            if (&req && cont_cnt_q != 16'hFFFF) begin
                cont_cnt_q <= cont_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        m0_grant_cnt   = m0_cnt_q;
        m1_grant_cnt   = m1_cnt_q;
        contention_cnt = cont_cnt_q;
    end
`endif

endmodule

// File: tb/tb_embed_onchip_mem_arbiter.sv
// Directed bench for embed_onchip_mem_arbiter with a behavioural 4096x32 RAM model.
// Stats checks are compiled in when ARB_STATS_EN is defined.
module tb_embed_onchip_mem_arbiter;

    logic        clk, reset;
    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;
`ifdef ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] m0_grant_cnt, m1_grant_cnt, contention_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram [0:4095];
    logic [11:0] ram_addr_q;

    embed_onchip_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
`ifdef ARB_STATS_EN
        .stats_clr        (stats_clr),
        .m0_grant_cnt     (m0_grant_cnt),
        .m1_grant_cnt     (m1_grant_cnt),
        .contention_cnt   (contention_cnt),
`endif
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM: registered address, byte-lane writes, unregistered q.
    always @(posedge clk) begin
        if (mem_clken) begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            ram_addr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    task automatic idle();
        m0_address = '0; m0_byteenable = 4'hF; m0_read = 0; m0_write = 0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = 4'hF; m1_read = 0; m1_write = 0; m1_writedata = '0;
`ifdef ARB_STATS_EN
        stats_clr = 0;
`endif
    endtask

    task automatic do_reset_cycle();
        @(negedge clk);
        idle();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        m0_read = 1; m1_read = 1;
        #1;
        n_tests++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_waitrequest: got %b%b expected 11", m0_waitrequest, m1_waitrequest);
        end
        n_tests++;
        if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_ctrl: got cs=%b wr=%b clken=%b expected 0 0 0",
                     mem_chipselect, mem_write, mem_clken);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdv: got %b%b expected 00", m0_readdatavalid, m1_readdatavalid);
        end
        idle();
        reset = 0;
    endtask

    task automatic test_single_write_read();
        @(negedge clk);
        idle();
        m0_write = 1; m0_address = 12'h010; m0_writedata = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b1 ||
            mem_address !== 12'h010) begin
            n_fail++;
            $display("FAIL single_write: got wait=%b cs=%b wr=%b addr=%h expected 0 1 1 010",
                     m0_waitrequest, mem_chipselect, mem_write, mem_address);
        end
        @(negedge clk);
        m0_write = 0; m0_read = 1;
        #1;
        n_tests++;
        if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b0 ||
            m0_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_issue: got wait=%b cs=%b wr=%b rdv=%b expected 0 1 0 0",
                     m0_waitrequest, mem_chipselect, mem_write, m0_readdatavalid);
        end
        @(negedge clk);
        m0_read = 0;
        #1;
        n_tests++;
        if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 ||
            m0_readdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_read_data: got rdv=%b/%b data=%h expected 1/0 deadbeef",
                     m0_readdatavalid, m1_readdatavalid, m0_readdata);
        end
        n_tests++;
        if (mem_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle_cs: got %b expected 0", mem_chipselect);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (m0_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rdv_clear: got %b expected 0", m0_readdatavalid);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_data;
        ram[1] = 32'h1111_0001;
        ram[2] = 32'h2222_0002;
        do_reset_cycle();
        m0_read = 1; m0_address = 12'h001;
        m1_read = 1; m1_address = 12'h002;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_tests++;
            if (m0_waitrequest !== k[0] || m1_waitrequest !== ~k[0] ||
                mem_address !== (k[0] ? 12'h002 : 12'h001)) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: got wait=%b%b addr=%h expected %b%b %h",
                         k, m0_waitrequest, m1_waitrequest, mem_address, k[0], ~k[0],
                         k[0] ? 12'h002 : 12'h001);
            end
            if (k > 0) begin
                exp_data = k[0] ? 32'h1111_0001 : 32'h2222_0002;
                n_tests++;
                if (m0_readdatavalid !== k[0] || m1_readdatavalid !== ~k[0] ||
                    m0_readdata !== exp_data) begin
                    n_fail++;
                    $display("FAIL contention_rdv[%0d]: got rdv=%b%b data=%h expected %b%b %h",
                             k, m0_readdatavalid, m1_readdatavalid, m0_readdata, k[0], ~k[0],
                             exp_data);
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_byteenable();
        @(negedge clk);
        idle();
        m1_write = 1; m1_address = 12'h020; m1_writedata = 32'hFFFFFFFF;
        @(negedge clk);
        m1_writedata = 32'h12345678; m1_byteenable = 4'b0011;
        #1;
        n_tests++;
        if (mem_byteenable !== 4'b0011 || mem_writedata !== 32'h12345678 || m1_waitrequest !== 0) begin
            n_fail++;
            $display("FAIL be_write_mux: got be=%b wd=%h wait=%b expected 0011 12345678 0",
                     mem_byteenable, mem_writedata, m1_waitrequest);
        end
        @(negedge clk);
        m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
        @(negedge clk);
        m1_read = 0;
        #1;
        n_tests++;
        if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 ||
            m1_readdata !== 32'hFFFF5678) begin
            n_fail++;
            $display("FAIL be_readback: got rdv=%b%b data=%h expected 01 ffff5678",
                     m0_readdatavalid, m1_readdatavalid, m1_readdata);
        end
    endtask

    task automatic test_read_and_write();
        @(negedge clk);
        idle();
        m0_read = 1; m0_write = 1; m0_address = 12'h030; m0_writedata = 32'hA5A5_0030;
        #1;
        n_tests++;
        if (mem_write !== 1'b1 || mem_chipselect !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_as_write: got cs=%b wr=%b expected 1 1", mem_chipselect, mem_write);
        end
        @(negedge clk);
        idle();
        #1;
        n_tests++;
        if (m0_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_no_response: got rdv=%b expected 0", m0_readdatavalid);
        end
    endtask

    task automatic test_back_to_back();
        ram[12'h100] = 32'hB0B0_0100;
        ram[12'h101] = 32'hB0B0_0101;
        ram[12'h102] = 32'hB0B0_0102;
        @(negedge clk);
        idle();
        m0_read = 1;
        for (int k = 0; k < 4; k++) begin
            m0_address = 12'h100 + 12'(k);
            if (k == 3) m0_read = 0;
            #1;
            if (k < 3) begin
                n_tests++;
                if (m0_waitrequest !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_wait[%0d]: got %b expected 0", k, m0_waitrequest);
                end
            end
            if (k > 0) begin
                n_tests++;
                if (m0_readdatavalid !== 1'b1 || m0_readdata !== (32'hB0B0_0100 + 32'(k - 1))) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got rdv=%b data=%h expected 1 %h", k,
                             m0_readdatavalid, m0_readdata, 32'hB0B0_0100 + 32'(k - 1));
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        idle();
        m0_read = 1; m0_address = 12'h010;
        @(negedge clk);
        m0_read = 0;
        reset = 1;
        #1;
        n_tests++;
        if (m0_readdatavalid !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 ||
            mem_clken !== 1'b0 || mem_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_read: got rdv=%b wait=%b%b clken=%b cs=%b expected 0 11 0 0",
                     m0_readdatavalid, m0_waitrequest, m1_waitrequest, mem_clken, mem_chipselect);
        end
        @(negedge clk);
        reset = 0;
        m0_read = 1; m0_address = 12'h001;
        m1_read = 1; m1_address = 12'h002;
        #1;
        n_tests++;
        if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || m0_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_contention: got wait=%b%b rdv=%b expected 01 0",
                     m0_waitrequest, m1_waitrequest, m0_readdatavalid);
        end
        @(negedge clk);
        idle();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset_cycle();
        m0_read = 1; m0_address = 12'h001;
        m1_read = 1; m1_address = 12'h002;
        repeat (10) @(negedge clk);
        idle();
        #1;
        n_tests++;
        if (m0_grant_cnt !== 16'd5 || m1_grant_cnt !== 16'd5 || contention_cnt !== 16'd10) begin
            n_fail++;
            $display("FAIL stats_count: got %0d %0d %0d expected 5 5 10",
                     m0_grant_cnt, m1_grant_cnt, contention_cnt);
        end
        stats_clr = 1;
        m0_read = 1;
        @(negedge clk);
        idle();
        #1;
        n_tests++;
        if (m0_grant_cnt !== 16'd0 || m1_grant_cnt !== 16'd0 || contention_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_clear: got %0d %0d %0d expected 0 0 0",
                     m0_grant_cnt, m1_grant_cnt, contention_cnt);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        ram_addr_q = '0;
        reset = 1;
        idle();
        test_reset();
        test_single_write_read();
        test_contention();
        test_byteenable();
        test_read_and_write();
        test_back_to_back();
        test_reset_mid_read();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/embed_onchip_mem_arbiter.md
# embed_onchip_mem_arbiter

Two-master arbiter that shares the single-port 4096 x 32 on-chip RAM slave between two Avalon-MM requesters, for example the CPU data master and a DMA/peripheral master. It sits between the interconnect masters and the RAM's s1 port. It grants at most one transfer per cycle using round-robin, stalls the losing master with waitrequest, and tracks the RAM's fixed one-cycle read latency so each master gets a pipelined readdatavalid response.

## Interface
- ADDR_W, 12, word address width (RAM depth 2^ADDR_W)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- mN_address  in  ADDR_W  master N word address (N = 0, 1)
- mN_byteenable  in  BE_W  master N byte lanes
- mN_read  in  1  master N read request
- mN_write  in  1  master N write request
- mN_writedata  in  DATA_W  master N write data
- mN_waitrequest  out  1  master N stalled; hold command
- mN_readdata  out  DATA_W  read data, broadcast to both masters
- mN_readdatavalid  out  1  master N read data valid
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken; equals ~reset
- mem_readdata  in  DATA_W  from RAM q (registered address, unregistered output)

## Operation
- reqN = mN_read | mN_write. If mN_read and mN_write are both high in one cycle, the command is treated as a write and the read is ignored.
- Grant is combinational within the cycle:
  - Only one master requests: that master is granted.
  - Both request: the master other than last_grant is granted.
- Grant effects:
  - mem_chipselect=1.
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master.
  - mem_write = granted master's write.
  - Granted mN_waitrequest=0. A requesting master that is not granted sees waitrequest=1.
  - A master that is not requesting sees waitrequest=0 (a don't-care for it).
- last_grant register: updated to the granted index on every grant, and held when there is no grant.
- Read tracking:
  - When a read is granted in cycle T: rd_pend<=1 and rd_owner<=index.
  - In cycle T+1: m[rd_owner]_readdatavalid=1 and mN_readdata=mem_readdata.
  - rd_pend clears the following cycle unless a new read is granted.
- Back-to-back reads, from either master, issue every cycle with no bubbles.
- Writes complete in the grant cycle and produce no response.
- With no grant: mem_chipselect=0, mem_write=0, and the mem_address mux holds master 0's address.

## Timing
- Read latency: exactly 1 cycle from the grant cycle (accept edge) to readdatavalid.
- Throughput: one transfer per cycle in aggregate.
- Under continuous contention each master receives every other cycle, so worst-case wait is 1 cycle.
- Reset values, and all outputs while reset=1:
  - last_grant=1 (master 0 wins the first contention).
  - rd_pend=0, mN_readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
  - mN_waitrequest=1 for both masters.
- Reset asserted in the cycle after a read grant: that read's readdatavalid is suppressed. Masters must reissue.
- Write in cycle T followed by a read of the same address in T+1 returns the new data (RAM port behaviour). The arbiter adds no bypass.
- No combinational path from mem_readdata to any waitrequest.

## Configuration
- ARB_STATS_EN defined: adds ports stats_clr (in, 1), m0_grant_cnt, m1_grant_cnt and contention_cnt (out, 16 each).
  - Grant counters increment on each grant to their master.
  - contention_cnt increments on each cycle where both masters request.
  - All counters saturate at 16'hFFFF.
  - Counters clear on reset or stats_clr. stats_clr has priority over a same-cycle increment.
- ARB_STATS_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical.

## Structure
- Shared package embed_mem_arb_pkg holds:
  - Parameter defaults ADDR_W, DATA_W, BE_W.
  - Localparam MEM_RD_LATENCY=1.
  - Typedef master index.
  - Typedef avalon command struct (address, byteenable, read, write, writedata).
- One natural sub-module, embed_rr_arb2: two-request round-robin grant logic with the last_grant register.
- Datapath muxing, read tracking and stats stay in the top module.

## Test plan
- Single master 0 writes 0xDEADBEEF to address 0x010, then reads 0x010 -> no waitrequest, mem_chipselect for 1 cycle each, m0_readdatavalid one cycle after the read grant, data 0xDEADBEEF.
- Both masters read continuously (m0 at 0x001, m1 at 0x002) from a post-reset start -> grants alternate m0,m1,m0,...; readdatavalid alternates with the correct data; each waitrequest high on alternate cycles.
- m1 writes 0x12345678 to 0x020 with byteenable 4'b0011 over prior 0xFFFFFFFF -> subsequent read returns 0xFFFF5678.
- Reset asserted in the cycle after an m0 read grant -> no m0_readdatavalid; all outputs at reset values; first contention after reset goes to m0.
- With ARB_STATS_EN: 10 contention cycles then stats_clr -> before the clear m0_grant_cnt=5, m1_grant_cnt=5, contention_cnt=10; all read 0 the cycle after stats_clr.
